// File: rtl/sc_tick_timer.sv
// ============================================================================
// Module  : sc_tick_timer
// Brief   : Down-count timer advanced by rising edges of a slow prescaler
//           clock, which is sampled as data, synchronized and edge-detected.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_tick_timer #(
  parameter int WIDTH = 8
) (
  input  logic             SC_TICKTIMER_CLOCK_50,
  input  logic             SC_TICKTIMER_RESET_InLow,
  input  logic             SC_TICKTIMER_TICKCLOCK_In,
  input  logic             SC_TICKTIMER_START_In,
  input  logic             SC_TICKTIMER_PAUSE_In,
  input  logic [WIDTH-1:0] SC_TICKTIMER_PRESET_In,
  output logic [WIDTH-1:0] SC_TICKTIMER_COUNT_Out,
  output logic             SC_TICKTIMER_BUSY_Out,
  output logic             SC_TICKTIMER_DONE_Out,
  output logic             SC_TICKTIMER_TICK_Out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_tick;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_done;

  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] w_count_next;
  logic             w_done_next;
  logic             w_busy;

  // State register, including the tick synchronizer and edge detector.
  always_ff @(posedge SC_TICKTIMER_CLOCK_50 or negedge SC_TICKTIMER_RESET_InLow) begin
    if (!SC_TICKTIMER_RESET_InLow) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_tick  <= 1'b0;
      r_state <= S_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_sync1 <= SC_TICKTIMER_TICKCLOCK_In;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_tick  <= r_sync2 & ~r_prev;
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state logic: START beats PAUSE, PAUSE beats a pending tick.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_done_next  = 1'b0;
    if (SC_TICKTIMER_START_In) begin
      w_count_next = SC_TICKTIMER_PRESET_In;
      if (SC_TICKTIMER_PRESET_In == '0) begin
        w_done_next  = 1'b1;
        w_state_next = S_IDLE;
      end else begin
        w_state_next = S_RUN;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
        end
        S_RUN: begin
          if (SC_TICKTIMER_PAUSE_In) begin
            w_state_next = S_PAUSE;
          end else if (r_tick && (r_count != '0)) begin
            w_count_next = r_count - WIDTH'(1);
            if (r_count == WIDTH'(1)) begin
              w_done_next  = 1'b1;
              w_state_next = S_IDLE;
            end
          end
        end
        S_PAUSE: begin
          if (!SC_TICKTIMER_PAUSE_In) begin
            w_state_next = S_RUN;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  assign SC_TICKTIMER_COUNT_Out = r_count;
  assign SC_TICKTIMER_BUSY_Out  = w_busy;
  assign SC_TICKTIMER_DONE_Out  = r_done;
  assign SC_TICKTIMER_TICK_Out  = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_sc_tick_timer.sv
// ============================================================================
// Module  : tb_sc_tick_timer
// Brief   : Self-checking bench for sc_tick_timer: cycle model plus directed
//           scenarios with literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_tick_timer;

  logic       clk;
  logic       rst_n;
  logic       tc;
  logic       tc_gen;
  logic       tc_man;
  logic       tc_en;
  logic       start;
  logic       pause;
  logic [7:0] preset;
  logic [7:0] dut_count;
  logic       dut_busy;
  logic       dut_done;
  logic       dut_tick;

  int n_pass  = 0;
  int n_total = 0;

  sc_tick_timer #(.WIDTH(8)) dut (
    .SC_TICKTIMER_CLOCK_50     (clk),
    .SC_TICKTIMER_RESET_InLow  (rst_n),
    .SC_TICKTIMER_TICKCLOCK_In (tc),
    .SC_TICKTIMER_START_In     (start),
    .SC_TICKTIMER_PAUSE_In     (pause),
    .SC_TICKTIMER_PRESET_In    (preset),
    .SC_TICKTIMER_COUNT_Out    (dut_count),
    .SC_TICKTIMER_BUSY_Out     (dut_busy),
    .SC_TICKTIMER_DONE_Out     (dut_done),
    .SC_TICKTIMER_TICK_Out     (dut_tick)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  assign tc = tc_en ? tc_gen : tc_man;

  // Free-running slow clock: 4 cycles high, 4 low.
  int tc_cnt = 0;
  initial tc_gen = 1'b0;
  always @(negedge clk) begin
    if (!tc_en) begin
      tc_cnt = 0;
    end else begin
      tc_cnt++;
      if (tc_cnt == 4) begin
        tc_gen = ~tc_gen;
        tc_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: the tick seen after edge e is the input sampled at e-2 being high
  // while it was low at e-3; the timer consumes that tick one edge later.
  bit hist [4];
  bit m_tick;
  int m_state;  // 0 idle, 1 running, 2 paused
  int m_count;
  bit m_done;

  always @(posedge clk) begin
    bit tick_prev;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] = 1'b0;
      m_tick = 0; m_state = 0; m_count = 0; m_done = 0;
    end else begin
      tick_prev = m_tick;
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = tc;
      m_tick = hist[2] & ~hist[3];
      m_done = 0;
      if (start) begin
        m_count = int'(preset);
        if (preset == 0) begin m_done = 1; m_state = 0; end
        else m_state = 1;
      end else if (m_state == 1) begin
        if (pause) m_state = 2;
        else if (tick_prev) begin
          m_count = m_count - 1;
          if (m_count == 0) begin m_done = 1; m_state = 0; end
        end
      end else if (m_state == 2 && !pause) begin
        m_state = 1;
      end
    end
    #1;
    chk("model_count", int'(dut_count), m_count);
    chk("model_busy", int'(dut_busy), (m_state != 0) ? 1 : 0);
    chk("model_done", int'(dut_done), int'(m_done));
    chk("model_tick", int'(dut_tick), int'(m_tick));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [7:0] p);
    preset = p;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (dut_done) seen = 1;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic wait_count(input string name, input int val, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (int'(dut_count) == val) seen = 1;
    end
    chk(name, int'(seen), 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; tc_en = 1'b0; tc_man = 1'b0;
    start = 1'b0; pause = 1'b0; preset = 8'd0;
    cyc(3);
    chk("reset_count", int'(dut_count), 0);
    chk("reset_busy", int'(dut_busy), 0);
    chk("reset_done", int'(dut_done), 0);
    chk("reset_tick", int'(dut_tick), 0);
    rst_n = 1'b1;
    cyc(2);

    // Basic count of 3 ticks
    tc_en = 1'b1;
    pulse_start(8'd3);
    chk("basic_start_count", int'(dut_count), 3);
    chk("basic_start_busy", int'(dut_busy), 1);
    wait_done("basic_done_seen", 60);
    chk("basic_done_count", int'(dut_count), 0);
    chk("basic_done_busy", int'(dut_busy), 0);
    cyc(1);
    chk("basic_done_one_cycle", int'(dut_done), 0);

    // Edge latency with a long high phase
    tc_en = 1'b0; tc_man = 1'b0;
    cyc(6);
    tc_man = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i <= 2) chk("latency_early_tick", int'(dut_tick), 0);
      if (i == 3) chk("latency_tick", int'(dut_tick), 1);
      n += int'(dut_tick);
    end
    chk("latency_single_tick", n, 1);
    tc_man = 1'b0;
    cyc(4);

    // Pause after the first tick
    tc_en = 1'b1;
    pulse_start(8'd4);
    wait_count("pause_reach3", 3, 40);
    pause = 1'b1;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n += int'(dut_tick);
    end
    chk("pause_ticks_visible", n, 3);
    chk("pause_count_hold", int'(dut_count), 3);
    chk("pause_busy", int'(dut_busy), 1);
    pause = 1'b0;
    wait_done("pause_done_seen", 60);
    chk("pause_done_count", int'(dut_count), 0);

    // Restart mid-run, then zero preset from idle
    pulse_start(8'd10);
    wait_count("restart_reach2", 2, 120);
    preset = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_count", int'(dut_count), 10);
    chk("restart_no_done", int'(dut_done), 0);
    wait_done("restart_done_seen", 120);
    cyc(2);
    pulse_start(8'd0);
    chk("zero_done", int'(dut_done), 1);
    chk("zero_busy", int'(dut_busy), 0);
    cyc(1);
    chk("zero_done_clear", int'(dut_done), 0);

    // Tick coincident with PAUSE at COUNT=1
    tc_en = 1'b0; tc_man = 1'b0;
    cyc(6);
    pulse_start(8'd1);
    tc_man = 1'b1;
    cyc(3);
    chk("simul_tick_present", int'(dut_tick), 1);
    pause = 1'b1;
    cyc(1);
    chk("simul_pause_busy", int'(dut_busy), 1);
    chk("simul_pause_count", int'(dut_count), 1);
    chk("simul_pause_no_done", int'(dut_done), 0);
    tc_man = 1'b0;
    cyc(4);
    pause = 1'b0;
    cyc(2);

    // Tick coincident with START
    tc_man = 1'b1;
    cyc(3);
    preset = 8'd5; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("simul_start_count", int'(dut_count), 5);
    cyc(1);
    chk("simul_start_tick_dropped", int'(dut_count), 5);

    // Asynchronous reset mid-count
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", int'(dut_count), 0);
    chk("async_reset_busy", int'(dut_busy), 0);
    cyc(3);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n += int'(dut_done);
    end
    chk("async_reset_no_done", n, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
